// File: rtl/audio_adc_rx.sv
// ---------------------------------------------------------------------------
// audio_adc_rx
//   Receive side of the codec audio serial link. Deserializes 16-bit I2S
//   samples from the codec ADC, oversampling BCLK/LRCK/DATA in the CLOCK_50
//   domain, and pushes the selected channel(s) into a single-clock FIFO write
//   port. Also maintains a decaying peak-level nibble for LED display.
//
// Parameters
//   CHAN_MODE    0 = left only, 1 = right only, 2 = stereo (L then R)
//   SAMPLE_BITS  bits captured per channel slot; later bits in a slot ignored
//   LEVEL_DECAY  log2 of CLOCK_50 cycles between level-meter decrements
//
// Ports
//   CLOCK_50     in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   capture enable, sampled only at LR-clock edges
//   AUD_BCLK     in   bit clock (asynchronous)
//   AUD_ADCLRCK  in   ADC LR clock: 0 = left slot, 1 = right slot
//   AUD_ADCDAT   in   serial ADC data, MSB first
//   fifo_full    in   FIFO full flag
//   fifo_wr      out  single-cycle write strobe
//   fifo_wr_dat  out  sample word (two's complement), held between writes
//   overflow     out  sticky: wanted word dropped because FIFO was full
//   frame_err    out  sticky: LR edge arrived before the word was complete
//   level        out  peak magnitude meter
// ---------------------------------------------------------------------------
module audio_adc_rx #(
    parameter int CHAN_MODE   = 2,
    parameter int SAMPLE_BITS = 16,
    parameter int LEVEL_DECAY = 20
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        AUD_BCLK,
    input  logic        AUD_ADCLRCK,
    input  logic        AUD_ADCDAT,
    input  logic        fifo_full,
    output logic        fifo_wr,
    output logic [15:0] fifo_wr_dat,
    output logic        overflow,
    output logic        frame_err,
    output logic [3:0]  level
);

    localparam int CNT_W = $clog2(SAMPLE_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // [0] first sync stage, [1] second sync stage, [2] edge-detect history
    logic [2:0]             r_bclk_sr;
    logic [2:0]             r_lrck_sr;
    logic [1:0]             r_dat_sr;

    logic [15:0]            r_shreg;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_slot;
    logic                   r_decide;
    logic                   r_fifo_wr;
    logic [15:0]            r_fifo_wr_dat;
    logic                   r_overflow;
    logic                   r_frame_err;
    logic [3:0]             r_level;
    logic [LEVEL_DECAY-1:0] r_decay_cnt;

    logic       w_bclk_rise;
    logic       w_lr_edge;
    logic       w_lrck;
    logic       w_dat;
    logic       w_start;
    logic       w_shift;
    logic       w_ferr_set;
    logic       w_enter_done;
    logic       w_wanted;
    logic       w_push;
    logic       w_drop;
    logic [3:0] w_peak;
    logic       w_load;
    logic       w_decay_tick;

    // ------------------------------------------------------------------
    // Input conditioning: data carries the same delay as BCLK
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_bclk_sr <= '0;
            r_lrck_sr <= '0;
            r_dat_sr  <= '0;
        end else begin
            r_bclk_sr <= {r_bclk_sr[1:0], AUD_BCLK};
            r_lrck_sr <= {r_lrck_sr[1:0], AUD_ADCLRCK};
            r_dat_sr  <= {r_dat_sr[0], AUD_ADCDAT};
        end
    end

    assign w_bclk_rise = r_bclk_sr[1] & ~r_bclk_sr[2];
    assign w_lr_edge   = r_lrck_sr[1] ^ r_lrck_sr[2];
    assign w_lrck      = r_lrck_sr[1];
    assign w_dat       = r_dat_sr[1];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. An LR edge in any state restarts the slot when
    // enabled, otherwise parks in IDLE (IDLE itself just stays).
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_lr_edge) begin
            w_state_nxt = enable ? S_SKIP : S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_SKIP:  if (w_bclk_rise) w_state_nxt = S_SHIFT;
                S_SHIFT: if (w_bclk_rise && (r_bit_cnt == CNT_W'(SAMPLE_BITS - 1)))
                             w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_start      = w_lr_edge & enable;
        w_shift      = (r_state == S_SHIFT) & w_bclk_rise & ~w_lr_edge;
        w_ferr_set   = w_lr_edge & ((r_state == S_SKIP) | (r_state == S_SHIFT));
        w_enter_done = (r_state == S_SHIFT) & (w_state_nxt == S_DONE);
    end

    // ------------------------------------------------------------------
    // Slot capture datapath
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_slot    <= 1'b0;
            r_decide  <= 1'b0;
        end else begin
            r_decide <= w_enter_done;
            if (w_start) begin
                r_shreg   <= '0;
                r_bit_cnt <= '0;
                r_slot    <= w_lrck;
            end else if (w_shift) begin
                r_shreg   <= {r_shreg[14:0], w_dat};
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Write decision, one cycle after entering DONE
    // ------------------------------------------------------------------
    assign w_wanted = (CHAN_MODE == 2) ? 1'b1 : (r_slot == (CHAN_MODE == 1));
    assign w_push   = r_decide & w_wanted & ~fifo_full;
    assign w_drop   = r_decide & w_wanted & fifo_full;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_wr     <= 1'b0;
            r_fifo_wr_dat <= '0;
            r_overflow    <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_fifo_wr <= w_push;
            if (w_push) r_fifo_wr_dat <= r_shreg;
            if (w_drop) r_overflow <= 1'b1;
            if (w_ferr_set) r_frame_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Level meter. Peak nibble is |word|[14:11] computed without a full
    // negation: for negative words ~w[14:11] plus a carry when w[10:0]==0.
    // 0x8000 saturates to 0x7FFF, i.e. nibble 0xF.
    // ------------------------------------------------------------------
    always_comb begin
        w_peak = r_shreg[14:11];
        if (r_shreg[15]) begin
            if (r_shreg[14:0] == '0) begin
                w_peak = 4'hF;
            end else begin
                w_peak = ~r_shreg[14:11] + {3'b000, (r_shreg[10:0] == '0)};
            end
        end
    end

    assign w_load       = r_decide & w_wanted & (w_peak > r_level);
    assign w_decay_tick = &r_decay_cnt;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_decay_cnt <= '0;
            r_level     <= '0;
        end else begin
            r_decay_cnt <= r_decay_cnt + LEVEL_DECAY'(1);
            if (w_load) begin
                r_level <= w_peak;
            end else if (w_decay_tick && (r_level != '0)) begin
                r_level <= r_level - 4'd1;
            end
        end
    end

    assign fifo_wr     = r_fifo_wr;
    assign fifo_wr_dat = r_fifo_wr_dat;
    assign overflow    = r_overflow;
    assign frame_err   = r_frame_err;
    assign level       = r_level;

endmodule

// File: tb/tb_audio_adc_rx.sv
// ---------------------------------------------------------------------------
// tb_audio_adc_rx
//   Drives I2S frames into three audio_adc_rx instances (stereo, right-only,
//   left-only) sharing the same pins. Expected words are pushed into
//   per-instance queues as slots are sent and popped when fifo_wr is seen.
// ---------------------------------------------------------------------------
module tb_audio_adc_rx;

    localparam int HALF = 8;   // CLOCK_50 cycles per BCLK half period

    logic CLOCK_50 = 1'b0;
    logic rst_n    = 1'b0;
    logic enable   = 1'b0;
    logic bclk     = 1'b1;
    logic lrck     = 1'b0;
    logic adcdat   = 1'b0;
    logic full     = 1'b0;

    logic        wr2, wr1, wr0;
    logic [15:0] dat2, dat1, dat0;
    logic        ovf2, ovf1, ovf0;
    logic        fe2, fe1, fe0;
    logic [3:0]  lvl2, lvl1, lvl0;

    int errors = 0;
    int checks = 0;

    logic [15:0] q2[$];
    logic [15:0] q1[$];
    logic [15:0] q0[$];
    logic [15:0] e2, e1, e0;
    int          wcnt2 = 0, wcnt1 = 0, wcnt0 = 0;

    logic lr_now   = 1'b0;
    logic exp_ovf2 = 1'b0, exp_ovf1 = 1'b0, exp_ovf0 = 1'b0;
    logic exp_fe   = 1'b0;

    always #10 CLOCK_50 = ~CLOCK_50;

    audio_adc_rx #(.CHAN_MODE(2), .SAMPLE_BITS(16), .LEVEL_DECAY(4)) dut (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n), .enable(enable), .AUD_BCLK(bclk),
        .AUD_ADCLRCK(lrck), .AUD_ADCDAT(adcdat), .fifo_full(full),
        .fifo_wr(wr2), .fifo_wr_dat(dat2), .overflow(ovf2), .frame_err(fe2), .level(lvl2)
    );

    audio_adc_rx #(.CHAN_MODE(1), .SAMPLE_BITS(16), .LEVEL_DECAY(4)) dut_r (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n), .enable(enable), .AUD_BCLK(bclk),
        .AUD_ADCLRCK(lrck), .AUD_ADCDAT(adcdat), .fifo_full(full),
        .fifo_wr(wr1), .fifo_wr_dat(dat1), .overflow(ovf1), .frame_err(fe1), .level(lvl1)
    );

    audio_adc_rx #(.CHAN_MODE(0), .SAMPLE_BITS(16), .LEVEL_DECAY(4)) dut_l (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n), .enable(enable), .AUD_BCLK(bclk),
        .AUD_ADCLRCK(lrck), .AUD_ADCDAT(adcdat), .fifo_full(full),
        .fifo_wr(wr0), .fifo_wr_dat(dat0), .overflow(ovf0), .frame_err(fe0), .level(lvl0)
    );

    // Scoreboard monitors: every sampled write pops one expected word, so a
    // strobe wider than one cycle shows up as an unexpected or wrong write.
    always @(negedge CLOCK_50) begin
        if (wr2) begin
            wcnt2++;
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL wr_stereo: unexpected write data=%h, none expected", dat2);
            end else begin
                e2 = q2.pop_front();
                if (dat2 !== e2) begin
                    errors++;
                    $display("FAIL wr_stereo: data=%h expected=%h", dat2, e2);
                end
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (wr1) begin
            wcnt1++;
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL wr_right: unexpected write data=%h, none expected", dat1);
            end else begin
                e1 = q1.pop_front();
                if (dat1 !== e1) begin
                    errors++;
                    $display("FAIL wr_right: data=%h expected=%h", dat1, e1);
                end
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (wr0) begin
            wcnt0++;
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL wr_left: unexpected write data=%h, none expected", dat0);
            end else begin
                e0 = q0.pop_front();
                if (dat0 !== e0) begin
                    errors++;
                    $display("FAIL wr_left: data=%h expected=%h", dat0, e0);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One BCLK period: falling edge drives LRCK/data, rising edge mid-period.
    task automatic bclk_cycle(input logic lr_v, input logic d);
        bclk   = 1'b0;
        lrck   = lr_v;
        adcdat = d;
        repeat (HALF) @(posedge CLOCK_50);
        #2;
        bclk = 1'b1;
        repeat (HALF) @(posedge CLOCK_50);
        #2;
    endtask

    // One LR slot of slotlen BCLKs: delay bit, then MSB-first word, then filler.
    // en_tog toggles enable at that BCLK index (>0) to exercise mid-slot changes.
    task automatic send_slot(input logic lr_v, input logic [15:0] w,
                             input int slotlen, input int en_tog);
        logic starts;
        starts = (lr_v != lr_now) && enable;
        if (starts && slotlen >= 17) begin
            if (full) begin
                exp_ovf2 = 1'b1;
                if (lr_v) exp_ovf1 = 1'b1;
                else      exp_ovf0 = 1'b1;
            end else begin
                q2.push_back(w);
                if (lr_v) q1.push_back(w);
                else      q0.push_back(w);
            end
        end else if (starts) begin
            exp_fe = 1'b1;
        end
        lr_now = lr_v;
        for (int k = 0; k < slotlen; k++) begin
            if (k == en_tog) enable = ~enable;
            bclk_cycle(lr_v, (k >= 1 && k <= 16) ? w[16-k] : 1'($urandom));
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        checks++;
        if ({wr2, dat2, ovf2, fe2, lvl2} !== 23'd0) begin
            errors++;
            $display("FAIL reset_stereo: outputs=%h expected=0", {wr2, dat2, ovf2, fe2, lvl2});
        end
        checks++;
        if ({wr1, dat1, ovf1, fe1, lvl1} !== 23'd0) begin
            errors++;
            $display("FAIL reset_right: outputs=%h expected=0", {wr1, dat1, ovf1, fe1, lvl1});
        end
        checks++;
        if ({wr0, dat0, ovf0, fe0, lvl0} !== 23'd0) begin
            errors++;
            $display("FAIL reset_left: outputs=%h expected=0", {wr0, dat0, ovf0, fe0, lvl0});
        end
        @(posedge CLOCK_50);
        #2;
        rst_n = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        checks++;
        if ({wr2, dat2, ovf2, fe2, lvl2} !== 23'd0) begin
            errors++;
            $display("FAIL idle_after_reset: outputs=%h expected=0", {wr2, dat2, ovf2, fe2, lvl2});
        end
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic test_stereo;
        enable = 1'b1;
        full   = 1'b0;
        send_slot(1'b1, 16'h0000, 20, -1);
        send_slot(1'b0, 16'h1234, 20, -1);
        send_slot(1'b1, 16'hFEDC, 20, -1);
        checks++;
        if (q2.size() != 0) begin
            errors++;
            $display("FAIL stereo_pending: left=%0d expected=0", q2.size());
        end
        checks++;
        if (dat2 !== 16'hFEDC) begin
            errors++;
            $display("FAIL stereo_hold: data=%h expected=fedc", dat2);
        end
        checks++;
        if ({ovf2, fe2} !== 2'b00) begin
            errors++;
            $display("FAIL stereo_flags: ovf,ferr=%b expected=00", {ovf2, fe2});
        end
    endtask

    task automatic test_mono;
        int start1;
        start1 = wcnt1;
        send_slot(1'b0, 16'hAAAA, 20, -1);
        send_slot(1'b1, 16'h5555, 20, -1);
        checks++;
        if (wcnt1 - start1 != 1) begin
            errors++;
            $display("FAIL mono_count: writes=%0d expected=1", wcnt1 - start1);
        end
        checks++;
        if (dat1 !== 16'h5555) begin
            errors++;
            $display("FAIL mono_right: data=%h expected=5555", dat1);
        end
        checks++;
        if (dat0 !== 16'hAAAA) begin
            errors++;
            $display("FAIL mono_left: data=%h expected=aaaa", dat0);
        end
    endtask

    task automatic test_full;
        send_slot(1'b0, 16'h0001, 20, -1);
        full = 1'b1;
        send_slot(1'b1, 16'h0002, 20, -1);
        full = 1'b0;
        send_slot(1'b0, 16'h0003, 20, -1);
        send_slot(1'b1, 16'h0004, 20, -1);
        checks++;
        if ({ovf2, ovf1, ovf0} !== {exp_ovf2, exp_ovf1, exp_ovf0}) begin
            errors++;
            $display("FAIL full_overflow: ovf(st,r,l)=%b expected=%b",
                     {ovf2, ovf1, ovf0}, {exp_ovf2, exp_ovf1, exp_ovf0});
        end
        checks++;
        if (q2.size() + q1.size() + q0.size() != 0) begin
            errors++;
            $display("FAIL full_pending: left=%0d expected=0", q2.size() + q1.size() + q0.size());
        end
    endtask

    task automatic test_short;
        send_slot(1'b0, 16'hFFFF, 11, -1);
        send_slot(1'b1, 16'h7777, 20, -1);
        send_slot(1'b0, 16'h0F0F, 20, -1);
        send_slot(1'b1, 16'h1111, 20, -1);
        checks++;
        if ({fe2, fe1, fe0} !== {3{exp_fe}}) begin
            errors++;
            $display("FAIL short_frame_err: ferr=%b expected=%b", {fe2, fe1, fe0}, {3{exp_fe}});
        end
        checks++;
        if (dat0 !== 16'h0F0F) begin
            errors++;
            $display("FAIL short_next_word: data=%h expected=0f0f", dat0);
        end
        checks++;
        if (q2.size() != 0) begin
            errors++;
            $display("FAIL short_pending: left=%0d expected=0", q2.size());
        end
    endtask

    task automatic test_reset_mid;
        int start2;
        send_slot(1'b0, 16'hC3C3, 9, -1);
        start2 = wcnt2;
        rst_n  = 1'b0;
        exp_fe = 1'b0;
        {exp_ovf2, exp_ovf1, exp_ovf0} = 3'b000;
        repeat (3) @(negedge CLOCK_50);
        checks++;
        if ({wr2, dat2, ovf2, fe2, lvl2} !== 23'd0) begin
            errors++;
            $display("FAIL midreset_outputs: outputs=%h expected=0", {wr2, dat2, ovf2, fe2, lvl2});
        end
        checks++;
        if ({ovf1, fe1, ovf0, fe0} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_flags: flags=%b expected=0000", {ovf1, fe1, ovf0, fe0});
        end
        @(posedge CLOCK_50);
        #2;
        rst_n = 1'b1;
        send_slot(1'b0, 16'hC3C3, 11, -1);
        checks++;
        if (wcnt2 != start2) begin
            errors++;
            $display("FAIL midreset_nowrite: writes=%0d expected=0", wcnt2 - start2);
        end
        send_slot(1'b1, 16'h2222, 20, -1);
        send_slot(1'b0, 16'h3C3C, 20, -1);
        send_slot(1'b1, 16'h4444, 20, -1);
        checks++;
        if (dat2 !== 16'h4444 || fe2 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_recover: data=%h ferr=%b expected=4444 0", dat2, fe2);
        end
        checks++;
        if (q2.size() + q1.size() + q0.size() != 0) begin
            errors++;
            $display("FAIL midreset_pending: left=%0d expected=0", q2.size() + q1.size() + q0.size());
        end
    endtask

    task automatic test_enable;
        send_slot(1'b0, 16'h1357, 20, 8);   // enable drops mid-word
        send_slot(1'b1, 16'h2468, 20, 5);   // enable returns mid-slot
        send_slot(1'b0, 16'h0ACE, 20, -1);
        send_slot(1'b1, 16'h0BDF, 20, -1);
        checks++;
        if (dat0 !== 16'h0ACE || dat1 !== 16'h0BDF) begin
            errors++;
            $display("FAIL enable_words: left=%h right=%h expected=0ace 0bdf", dat0, dat1);
        end
        checks++;
        if (q2.size() + q1.size() + q0.size() != 0) begin
            errors++;
            $display("FAIL enable_pending: left=%0d expected=0", q2.size() + q1.size() + q0.size());
        end
    endtask

    task automatic test_level;
        fork
            send_slot(~lr_now, 16'h8000, 17, -1);
            begin : watch
                int          found;
                int          last;
                int          steps;
                logic [3:0]  prev;
                found = 0;
                for (int i = 0; i < 1000 && found == 0; i++) begin
                    @(negedge CLOCK_50);
                    if (wr2) found = 1;
                end
                checks++;
                if (found == 0) begin
                    errors++;
                    $display("FAIL level_write_timeout: no write seen, expected one");
                end else begin
                    checks++;
                    if (lvl2 !== 4'hF) begin
                        errors++;
                        $display("FAIL level_load: level=%0d expected=15", lvl2);
                    end
                    prev  = lvl2;
                    last  = -1;
                    steps = 0;
                    for (int i = 1; i <= 400; i++) begin
                        @(negedge CLOCK_50);
                        if (lvl2 !== prev) begin
                            checks++;
                            if (int'(lvl2) != int'(prev) - 1) begin
                                errors++;
                                $display("FAIL level_step: level=%0d expected=%0d", lvl2, int'(prev) - 1);
                            end
                            if (last >= 0) begin
                                checks++;
                                if (i - last != 16) begin
                                    errors++;
                                    $display("FAIL level_period: interval=%0d expected=16", i - last);
                                end
                            end
                            last = i;
                            steps++;
                            prev = lvl2;
                        end
                    end
                    checks++;
                    if (lvl2 !== 4'd0 || steps != 15) begin
                        errors++;
                        $display("FAIL level_final: level=%0d steps=%0d expected=0 15", lvl2, steps);
                    end
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_stereo();
        test_mono();
        test_full();
        test_short();
        test_reset_mid();
        test_enable();
        test_level();
        repeat (20) @(negedge CLOCK_50);
        checks++;
        if (q2.size() + q1.size() + q0.size() != 0) begin
            errors++;
            $display("FAIL final_pending: left=%0d expected=0", q2.size() + q1.size() + q0.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_adc_rx.md
Name: audio_adc_rx

Overview:
- Receive side of the codec audio serial link; the counterpart of the I2S DAC transmitter path that plays SD-card audio.
- Deserializes 16-bit I2S samples from the codec ADC (AUD_ADCDAT) using the shared BCLK and the ADC LR clock, all oversampled in the CLOCK_50 domain.
- Pushes the selected channel(s) into a single-clock FIFO write port, which feeds the SD write path or a loopback.
- Also provides a peak-level nibble for LED display.

Parameters:
- CHAN_MODE, 2, channel selection: 0 = left only, 1 = right only, 2 = stereo (L then R pushed as consecutive words).
- SAMPLE_BITS, 16, bits captured per channel slot; any extra bits in a slot are ignored.
- LEVEL_DECAY, 20, log2 of the CLOCK_50 cycles between 1-step decrements of the level meter.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset; driven from KEY[0].
- enable  in  1  capture enable; sampled only at LR-clock edges.
- AUD_BCLK  in  1  bit clock (shared with the DAC transmitter); asynchronous to CLOCK_50.
- AUD_ADCLRCK  in  1  ADC LR clock: 0 = left slot, 1 = right slot.
- AUD_ADCDAT  in  1  serial ADC data, MSB first.
- fifo_full  in  1  FIFO write-side full flag.
- fifo_wr  out  1  single-cycle write strobe.
- fifo_wr_dat  out  16  sample word, two's complement.
- overflow  out  1  sticky; set when a word is dropped because fifo_full=1; cleared only by reset.
- frame_err  out  1  sticky; set when an LR edge arrives before SAMPLE_BITS bits have been captured.
- level  out  4  peak magnitude meter.

Behaviour:
- Input conditioning
  - AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT each pass through a 2-FF synchronizer, plus one history register for edge detection.
  - The data path carries the same delay as BCLK, so alignment is preserved.
  - bclk_rise = sync=1 and history=0. lr_edge = any change of the synchronized LRCK.
- Reset values
  - fifo_wr=0, fifo_wr_dat=0, overflow=0, frame_err=0, level=0.
  - Shift register 0, bit counter 0, state IDLE.
  - An asynchronous reset mid-word discards the partial word; no write is issued.
- I2S format
  - The MSB is sampled on the 2nd bclk_rise after lr_edge; the 1st rise after the edge is the I2S delay slot and is skipped.
  - Subsequent bits are sampled on successive bclk_rise.
- FSM
  - IDLE: on lr_edge with enable=1, latch slot = new LRCK value, clear the counter, go to SKIP.
  - SKIP: on bclk_rise, go to SHIFT.
  - SHIFT:
    - On each bclk_rise: shift in ADCDAT at the LSB and increment the counter.
    - When the counter reaches SAMPLE_BITS, go to DONE.
    - An lr_edge seen in SHIFT sets frame_err, discards the word, and restarts as if from IDLE with the new slot, provided enable=1.
  - DONE:
    - In the cycle after entering DONE, perform the write decision.
    - Then wait for lr_edge, where the IDLE rules apply (enable=0 means go to IDLE).
    - Extra bits in the slot are ignored.
- Write decision
  - A word is wanted when its slot matches CHAN_MODE: mode 0 takes slot 0, mode 1 takes slot 1, mode 2 takes both.
  - If wanted and fifo_full=0: fifo_wr=1 for exactly one cycle, with fifo_wr_dat = the captured word in that same cycle.
  - If wanted and fifo_full=1: no write, overflow is set.
  - fifo_wr_dat holds its value between writes.
- Latency
  - fifo_wr asserts 2 CLOCK_50 cycles after the cycle in which the 16th bclk_rise is detected.
  - That is 4 cycles after the pin edge, counting 2 cycles of sync.
- Enable
  - Deasserting enable mid-word completes the current word; no new word starts.
  - Asserting enable mid-slot waits for the next lr_edge, so partial slots are never captured.
- Level meter
  - mag = |word|, with 0x8000 treated as 0x7FFF.
  - On every captured word (written or dropped), if mag[14:11] > level, load level = mag[14:11].
  - Independently, a free-running 2^LEVEL_DECAY counter decrements level by 1 on wrap, saturating at 0.
  - A load in the same cycle as a decay wins over the decay.
- Limits: BCLK must be ≤ CLOCK_50/4, i.e. ≥ 2 cycles high and ≥ 2 cycles low. Behaviour for faster BCLK is undefined.

Test Plan:
- Stereo basic: CHAN_MODE=2, BCLK=3.072 MHz, send L=0x1234, R=0xFEDC → two fifo_wr pulses with fifo_wr_dat 0x1234 then 0xFEDC, each exactly 1 cycle wide; overflow=0, frame_err=0.
- Mono select: CHAN_MODE=1, send L=0xAAAA, R=0x5555 → exactly one write, data 0x5555.
- Full: hold fifo_full=1 during the R slot of L=0x0001, R=0x0002 → only 0x0001 written; overflow=1 and remains 1 after fifo_full drops.
- Short slot: toggle LRCK after 10 bits, then send a complete frame with L=0x0F0F → frame_err=1, no write for the short word, next word 0x0F0F written correctly.
- Reset mid-word: pull rst_n low after 8 bits of 0xC3C3, release before the next LR edge → all outputs 0 and no write; the next full frame is captured correctly.
- Level: write word 0x8000, then silence with LEVEL_DECAY=4 → level=15 immediately after the word, then decrements by 1 every 16 cycles to 0 and holds at 0.
